// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store engine for a word-organised data memory
// Ports: clk, rst (async, active-high); req/op/addr/wdata request, rdata/busy/done/err status;
//        A/WD/WE/RD memory side (asynchronous read, synchronous write).
module load_store_unit #(
   parameter int WORDS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [3:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] A,
   output logic [31:0] WD,
   output logic        WE,
   input  logic [31:0] RD
);
   typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, ERR, DONE} state_t;
   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, merge_q, merge_d, rdata_q, rdata_d;
   logic        err_q, err_d, bad;
   logic [4:0]  sh;
   logic [31:0] shifted, lane_mask, ld_val;
   always_comb begin
      bad = op[1:0] == 2'b11 || (op[1:0] == 2'b01 && addr[0]) ||
            (op[1:0] == 2'b10 && addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(WORDS));
      sh = {addr_q[1:0], 3'b000};
      // aligned accesses only reach here, so the shifted word itself is the word-load result
      shifted = RD >> sh;
      ld_val = op_q[1:0] == 2'b00 ? {{24{shifted[7] & ~op_q[2]}}, shifted[7:0]} :
               op_q[1:0] == 2'b01 ? {{16{shifted[15] & ~op_q[2]}}, shifted[15:0]} : shifted;
      lane_mask = (op_q[1:0] == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      state_d = state_q;
      op_d = op_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      err_d = err_q;
      merge_d = merge_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: if (req) begin
            op_d = op[2:0];
            addr_d = addr;
            wdata_d = wdata;
            err_d = bad;
            state_d = bad ? ERR : !op[3] ? LOAD : op[1:0] == 2'b10 ? WRITE : RMW_READ;
         end
         LOAD: begin
            rdata_d = ld_val;
            state_d = DONE;
         end
         RMW_READ: begin
            merge_d = (RD & ~lane_mask) | ((wdata_q << sh) & lane_mask);
            state_d = WRITE;
         end
         WRITE:   state_d = DONE;
         ERR:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         err_q <= 1'b0;
         merge_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         err_q <= err_d;
         merge_q <= merge_d;
         rdata_q <= rdata_d;
      end
   end
   // memory-side outputs decode from the state register, so reset removes WE at once
   assign busy = state_q != IDLE;
   assign done = state_q == DONE;
   assign err = done && err_q;
   assign WE = state_q == WRITE;
   assign A = (state_q == LOAD || state_q == RMW_READ || state_q == WRITE) ? {2'b00, addr_q[31:2]} : '0;
   assign WD = WE ? (op_q[1:0] == 2'b10 ? wdata_q : merge_q) : '0;
   assign rdata = rdata_q;
endmodule
